color_blend_rmw: RTL and testbench

- Read-modify-write front/back end for the color blender.
- Accepts a fragment stream (pixel address + RGBA source color) and issues the color-buffer read that supplies the destination color.
- Presents the aligned source/dest pair to the blender, then writes the blended result back to the color buffer.
- Tracks all in-flight fragments and stalls the input on read-after-write address hazards, so overlapping fragments always blend against up-to-date dest data.

---
 rtl/color_blend_rmw.sv | 99 +++++++++
 tb/tb_color_blend_rmw.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_blend_rmw.sv
// Read-modify-write wrapper around the color blender. Each accepted fragment
// issues a color-buffer read, meets its dest color READ_LATENCY cycles later,
// and has its blended result written back after READ_LATENCY + BLEND_LATENCY cycles.
// Input is stalled while any in-flight fragment targets the same address.
module color_blend_rmw #(
  parameter int unsigned SUB_PIXEL_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned BLEND_LATENCY   = 3,
  localparam int unsigned PIXEL_WIDTH    = 4 * SUB_PIXEL_WIDTH
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ADDR_WIDTH-1:0]  s_addr,
  input  logic [PIXEL_WIDTH-1:0] s_color,
  output logic                   mem_ren,
  output logic [ADDR_WIDTH-1:0]  mem_raddr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic                   mem_wen,
  output logic [ADDR_WIDTH-1:0]  mem_waddr,
  output logic [PIXEL_WIDTH-1:0] mem_wdata,
  output logic [PIXEL_WIDTH-1:0] blend_source_color,
  output logic [PIXEL_WIDTH-1:0] blend_dest_color,
  input  logic [PIXEL_WIDTH-1:0] blend_color,
  output logic                   busy,
  output logic [15:0]            frag_count
);

  localparam int unsigned Depth = READ_LATENCY + BLEND_LATENCY;

  // Index k holds pipeline stage k+1.
  logic [Depth-1:0]       vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]  addr_q  [Depth];
  // Source color is only consumed at the dest-alignment stage, so it is not
  // carried beyond it.
  logic [PIXEL_WIDTH-1:0] color_q [READ_LATENCY];
  logic [15:0]            frag_count_q, frag_count_d;
  logic                   hazard;
  logic                   accept;

  // Read-after-write hazard: any valid stage, including the one writing this
  // cycle, holding the incoming address blocks acceptance.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < Depth; k++) begin
      if (vld_q[k] && (addr_q[k] == s_addr)) begin
        hazard = 1'b1;
      end
    end
  end

  assign s_ready   = !reset && !hazard;
  assign accept    = s_valid && s_ready;
  assign mem_ren   = accept;
  assign mem_raddr = s_addr;

  assign blend_source_color = color_q[READ_LATENCY-1];
  assign blend_dest_color   = mem_rdata;

  // Reset gates the enables so nothing in flight commits in the reset cycle.
  assign mem_wen   = vld_q[Depth-1] && !reset;
  assign mem_waddr = addr_q[Depth-1];
  assign mem_wdata = blend_color;

  assign busy       = (|vld_q) && !reset;
  assign frag_count = frag_count_q;

  // Next-state for stage valids and the writeback counter.
  always_comb begin
    vld_d        = {vld_q[Depth-2:0], accept};
    frag_count_d = frag_count_q + 16'(mem_wen);
  end

  // Control state: stage valids and completed-writeback count.
  always_ff @(posedge aclk) begin
    if (reset) begin
      vld_q        <= '0;
      frag_count_q <= '0;
    end else begin
      vld_q        <= vld_d;
      frag_count_q <= frag_count_d;
    end
  end

  // Data stages shift every cycle; contents of idle stages are don't-care.
  always_ff @(posedge aclk) begin
    addr_q[0]  <= s_addr;
    color_q[0] <= s_color;
    for (int unsigned k = 1; k < Depth; k++) begin
      addr_q[k] <= addr_q[k-1];
    end
    for (int unsigned k = 1; k < READ_LATENCY; k++) begin
      color_q[k] <= color_q[k-1];
    end
  end

endmodule

// File: tb/tb_color_blend_rmw.sv
// Scoreboard bench for color_blend_rmw: a behavioural color-buffer model and a
// fixed-latency saturating-add blender surround the DUT; expected writes are
// derived from a shadow copy of the buffer updated in fragment-accept order.
module tb_color_blend_rmw;

  localparam int AW = 16;
  localparam int PW = 32;
  localparam int RL = 1;
  localparam int BL = 3;
  localparam int D  = RL + BL;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] s_addr = '0;
  logic [PW-1:0] s_color = '0;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [PW-1:0] mem_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [PW-1:0] mem_wdata;
  logic [PW-1:0] blend_source_color;
  logic [PW-1:0] blend_dest_color;
  logic [PW-1:0] blend_color;
  logic          busy;
  logic [15:0]   frag_count;

  color_blend_rmw #(
    .SUB_PIXEL_WIDTH(8),
    .ADDR_WIDTH     (AW),
    .READ_LATENCY   (RL),
    .BLEND_LATENCY  (BL)
  ) dut (
    .aclk              (aclk),
    .reset             (reset),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_addr            (s_addr),
    .s_color           (s_color),
    .mem_ren           (mem_ren),
    .mem_raddr         (mem_raddr),
    .mem_rdata         (mem_rdata),
    .mem_wen           (mem_wen),
    .mem_waddr         (mem_waddr),
    .mem_wdata         (mem_wdata),
    .blend_source_color(blend_source_color),
    .blend_dest_color  (blend_dest_color),
    .blend_color       (blend_color),
    .busy              (busy),
    .frag_count        (frag_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  typedef struct {
    int            due;
    logic [PW-1:0] src;
    logic [PW-1:0] dst;
  } bl_t;

  wr_t           wq[$];
  bl_t           bq[$];
  int            last_acc[int];
  logic [PW-1:0] mem[65536];
  logic [PW-1:0] shadow[65536];
  logic [PW-1:0] rd_pipe[RL];
  logic [PW-1:0] bp[BL];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [15:0]   count_acc = '0;

  // Per-channel saturating add.
  function automatic logic [PW-1:0] blend_f(input logic [PW-1:0] s, input logic [PW-1:0] d);
    logic [PW-1:0] r;
    int sum;
    for (int ch = 0; ch < 4; ch++) begin
      sum = int'(s[8*ch +: 8]) + int'(d[8*ch +: 8]);
      r[8*ch +: 8] = (sum > 255) ? 8'hFF : 8'(sum);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Color buffer: registered read, write committed at the clock edge.
  always @(posedge aclk) begin
    if (mem_ren) rd_pipe[0] <= mem[mem_raddr];
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = rd_pipe[RL-1];

  // Fixed-latency blender.
  always @(posedge aclk) begin
    bp[0] <= blend_f(blend_source_color, blend_dest_color);
    for (int k = 1; k < BL; k++) bp[k] <= bp[k-1];
  end
  assign blend_color = bp[BL-1];

  // Monitor: compares DUT outputs against scoreboard entries as they fall due.
  always @(negedge aclk) begin
    wr_t e;
    bl_t b;
    if (reset) check("reset_ctrl", {mem_wen, mem_ren, s_ready, busy}, 4'b0000);
    if (mem_wen) begin
      if (wq.size() == 0) begin
        check("spurious_wen", mem_wen, 1'b0);
      end else begin
        e = wq.pop_front();
        check("waddr", mem_waddr, e.addr);
        check("wdata", mem_wdata, e.data);
        check("wcycle", cyc, e.due);
      end
    end else if (wq.size() > 0 && wq[0].due <= cyc) begin
      check("missing_wen", mem_wen, 1'b1);
      void'(wq.pop_front());
    end
    if (bq.size() > 0 && bq[0].due <= cyc) begin
      b = bq.pop_front();
      check("blend_src", blend_source_color, b.src);
      check("blend_dst", blend_dest_color, b.dst);
    end
    if (!s_valid && mem_ren) check("ren_idle", mem_ren, 1'b0);
  end

  // Offer one fragment; holds it until accepted and records the expected response.
  task automatic send(input logic [AW-1:0] a, input logic [PW-1:0] c, output int stalls);
    bit            exp_rdy;
    logic [PW-1:0] res;
    s_valid = 1'b1;
    s_addr  = a;
    s_color = c;
    stalls  = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge aclk);
      exp_rdy = !(last_acc.exists(int'(a)) && (cyc - last_acc[int'(a)]) <= D);
      check("s_ready", s_ready, exp_rdy);
      if (s_ready) begin
        check("mem_read", {mem_ren, mem_raddr}, {1'b1, a});
        res = blend_f(c, shadow[a]);
        wq.push_back('{due: cyc + D, addr: a, data: res});
        bq.push_back('{due: cyc + RL, src: c, dst: shadow[a]});
        shadow[a] = res;
        last_acc[int'(a)] = cyc;
        count_acc++;
        @(posedge aclk);
        #1;
        return;
      end
      check("ren_stall", mem_ren, 1'b0);
      stalls++;
      @(posedge aclk);
      #1;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL accept_timeout: addr %0h not accepted within 64 cycles", a);
    s_valid = 1'b0;
  endtask

  // Wait for every expected write, then check the idle state.
  task automatic drain();
    s_valid = 1'b0;
    for (int i = 0; i < 40 && (wq.size() != 0 || bq.size() != 0); i++) begin
      @(posedge aclk);
      #1;
    end
    if (wq.size() != 0 || bq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d writes still outstanding", wq.size());
      wq.delete();
      bq.delete();
    end
    @(negedge aclk);
    check("busy_idle", busy, 1'b0);
    check("frag_count", frag_count, count_acc);
    @(posedge aclk);
    #1;
  endtask

  // Two-cycle reset; in-flight fragments are dropped from the model too.
  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    wq.delete();
    bq.delete();
    last_acc.delete();
    count_acc = '0;
    for (int i = 0; i < 65536; i++) shadow[i] = mem[i];
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("reset_frag_count", frag_count, 16'h0000);
    @(posedge aclk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int st;
    int tot;
    logic [AW-1:0] a;
    for (int i = 0; i < 65536; i++) mem[i] <= $urandom;
    mem[16'h0010] <= 32'hAABBCCDD;
    #1;
    do_reset();

    // Single fragment.
    send(16'h0010, 32'h11223344, st);
    check("t1_stall", st, 0);
    drain();

    // Distinct addresses stream at full rate.
    tot = 0;
    for (int i = 0; i < 100; i++) begin
      send(AW'(i), $urandom, st);
      tot += st;
    end
    check("t2_stalls", tot, 0);
    drain();

    // Same address back-to-back.
    send(16'h0005, $urandom, st);
    send(16'h0005, $urandom, st);
    check("t3_stall", st, D);
    drain();

    // A, B, A interleave.
    send(16'h0020, $urandom, st);
    send(16'h0021, $urandom, st);
    check("t4_b_stall", st, 0);
    send(16'h0020, $urandom, st);
    check("t4_a2_stall", st, D - 1);
    drain();

    // Reset with three fragments in flight.
    for (int i = 0; i < 3; i++) send(AW'(16'h0030 + i), $urandom, st);
    do_reset();
    send(16'h0040, $urandom, st);
    check("t5_first_accept", st, 0);
    drain();

    // Random traffic over a small address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      a = AW'(16'h0100 + $urandom_range(0, 7));
      send(a, $urandom, st);
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge aclk);
        #1;
      end
    end
    drain();

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 65535; i++) send(AW'(i), $urandom, st);
    drain();
    check("t6_count_max", frag_count, 16'hFFFF);
    send(16'h1234, $urandom, st);
    drain();
    check("t6_count_wrap", frag_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
